// File: rtl/uart_rx_controller_if.sv
// Bundle of the receiver-control, receiver-status and FIFO read signals.
// The controller attaches through the slave modport; whatever drives the
// controller (host logic plus receiver model) attaches through master.
interface uart_rx_controller_if;
   // Enable / configuration
   logic       enable;
   logic       cfg_load;
   logic [2:0] cfg_baud;
   logic       Rx_EN;
   logic [2:0] baud_select;

   // Receiver status
   logic       Rx_VALID;
   logic       Rx_FERROR;
   logic       Rx_PERROR;
   logic [7:0] Rx_DATA;

   // FIFO read side and status
   logic       rd_en;
   logic [7:0] rd_data;
   logic       rd_valid;
   logic       fifo_empty;
   logic       fifo_full;
   logic       overrun;
   logic       err_clr;
   logic [7:0] err_count;

   modport master (
      output enable, cfg_load, cfg_baud,
      output Rx_VALID, Rx_FERROR, Rx_PERROR, Rx_DATA,
      output rd_en, err_clr,
      input  Rx_EN, baud_select,
      input  rd_data, rd_valid, fifo_empty, fifo_full, overrun, err_count
   );

   modport slave (
      input  enable, cfg_load, cfg_baud,
      input  Rx_VALID, Rx_FERROR, Rx_PERROR, Rx_DATA,
      input  rd_en, err_clr,
      output Rx_EN, baud_select,
      output rd_data, rd_valid, fifo_empty, fifo_full, overrun, err_count
   );
endinterface

// File: rtl/uart_rx_controller.sv
// UART receiver controller: sequences the receiver enable around baud-rate
// changes (with a quiet period), captures received bytes into a small FIFO
// on the rising edge of Rx_VALID, and keeps a sticky overrun flag and a
// saturating error counter.
module uart_rx_controller #(
   parameter int DEPTH        = 4,   // FIFO depth in bytes, power of two 2..16
   parameter int QUIET_CYCLES = 16   // clocks Rx_EN stays low on reconfiguration
) (
   input logic                 clk,
   input logic                 reset,
   uart_rx_controller_if.slave bus
);

   localparam int AW = $clog2(DEPTH);             // FIFO index width
   localparam int PW = AW + 1;                    // pointer width (extra wrap bit)
   localparam int QW = $clog2(QUIET_CYCLES + 1);  // quiet counter width
   localparam logic [QW-1:0] QUIET_LOAD = QW'(QUIET_CYCLES - 1);

   typedef enum logic [1:0] {
      DISABLED = 2'd0,
      ACTIVE   = 2'd1,
      QUIESCE  = 2'd2
   } state_t;

   // ---------------------------------------------------------------------
   // Enable / reconfiguration state machine
   // ---------------------------------------------------------------------
   state_t        state_reg, state_next;
   logic [QW-1:0] quiet_cnt_reg, quiet_cnt_next;
   logic          rx_en_reg;
   logic [2:0]    baud_reg;

   // Next-state and quiet-counter logic. A cfg_load always wins over the
   // enable level so a baud change can never be skipped.
   always_comb begin
      state_next     = state_reg;
      quiet_cnt_next = quiet_cnt_reg;
      case (state_reg)
         DISABLED: begin
            if (!bus.cfg_load && bus.enable) begin
               state_next = ACTIVE;
            end
         end
         ACTIVE: begin
            if (bus.cfg_load) begin
               state_next     = QUIESCE;
               quiet_cnt_next = QUIET_LOAD;
            end else if (!bus.enable) begin
               state_next = DISABLED;
            end
         end
         QUIESCE: begin
            if (bus.cfg_load) begin
               quiet_cnt_next = QUIET_LOAD;
            end else if (quiet_cnt_reg == '0) begin
               state_next = bus.enable ? ACTIVE : DISABLED;
            end else begin
               quiet_cnt_next = quiet_cnt_reg - QW'(1);
            end
         end
         default: begin
            state_next = DISABLED;
         end
      endcase
   end

   // State register; Rx_EN is registered from the next state so it tracks
   // ACTIVE exactly without a combinational decode on the output.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg     <= DISABLED;
         quiet_cnt_reg <= '0;
         rx_en_reg     <= 1'b0;
      end else begin
         state_reg     <= state_next;
         quiet_cnt_reg <= quiet_cnt_next;
         rx_en_reg     <= (state_next == ACTIVE);
      end
   end

   // Baud code register: every cfg_load takes effect on the next edge,
   // whatever the state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         baud_reg <= 3'b000;
      end else if (bus.cfg_load) begin
         baud_reg <= bus.cfg_baud;
      end
   end

   // ---------------------------------------------------------------------
   // Byte capture and FIFO
   // ---------------------------------------------------------------------
   logic          valid_d_reg;
   logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
   logic [7:0]    mem [DEPTH];
   logic [7:0]    rd_data_reg;
   logic          rd_valid_reg;
   logic          overrun_reg;
   logic [7:0]    err_count_reg;

   logic fifo_empty;
   logic fifo_full;
   logic push_evt;   // rising edge of Rx_VALID
   logic pop_ok;     // accepted read
   logic push_ok;    // byte actually stored
   logic drop_evt;   // byte lost because the FIFO is full
   logic err_evt;

   // Occupancy flags come straight from the pointers: equal pointers mean
   // empty, equal indices with differing wrap bits mean full.
   assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
   assign fifo_full  = (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]) &&
                       (wr_ptr_reg[AW] != rd_ptr_reg[AW]);

   assign push_evt = bus.Rx_VALID & ~valid_d_reg;
   assign pop_ok   = bus.rd_en & ~fifo_empty;
   // A pop in the same cycle frees a slot, so a full FIFO still accepts.
   assign push_ok  = push_evt & (~fifo_full | pop_ok);
   assign drop_evt = push_evt & fifo_full & ~pop_ok;
   assign err_evt  = bus.Rx_FERROR | bus.Rx_PERROR;

   // Rx_VALID delay register for edge detection.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_d_reg <= 1'b0;
      end else begin
         valid_d_reg <= bus.Rx_VALID;
      end
   end

   // Storage array: write port only, no reset so it maps onto RAM. When the
   // FIFO is full the write slot equals the read slot, and the read below
   // sees the old byte because both use the pre-edge contents.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr_reg[AW-1:0]] <= bus.Rx_DATA;
      end
   end

   // Pointer update; pointers wrap naturally modulo 2*DEPTH.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr_reg <= wr_ptr_reg + PW'(1);
         end
         if (pop_ok) begin
            rd_ptr_reg <= rd_ptr_reg + PW'(1);
         end
      end
   end

   // Registered read port and its one-cycle qualifier.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_data_reg  <= 8'h00;
         rd_valid_reg <= 1'b0;
      end else begin
         rd_valid_reg <= pop_ok;
         if (pop_ok) begin
            rd_data_reg <= mem[rd_ptr_reg[AW-1:0]];
         end
      end
   end

   // Sticky overrun flag; a clear in the same cycle as a drop wins.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         overrun_reg <= 1'b0;
      end else if (bus.err_clr) begin
         overrun_reg <= 1'b0;
      end else if (drop_evt) begin
         overrun_reg <= 1'b1;
      end
   end

   // Saturating error counter, one count per cycle with an error strobe.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err_count_reg <= 8'h00;
      end else if (bus.err_clr) begin
         err_count_reg <= 8'h00;
      end else if (err_evt && (err_count_reg != 8'hFF)) begin
         err_count_reg <= err_count_reg + 8'h01;
      end
   end

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   assign bus.Rx_EN       = rx_en_reg;
   assign bus.baud_select = baud_reg;
   assign bus.rd_data     = rd_data_reg;
   assign bus.rd_valid    = rd_valid_reg;
   assign bus.fifo_empty  = fifo_empty;
   assign bus.fifo_full   = fifo_full;
   assign bus.overrun     = overrun_reg;
   assign bus.err_count   = err_count_reg;

endmodule
